// File: rtl/bingame_pkg.sv
// Shared types and constants for the binary-counting game round controller.
package bingame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam int         LFSR_W    = 8;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;   // x^8+x^6+x^5+x^4+1, Galois right-shift form
    localparam logic [3:0] SCORE_MAX = 4'd15;
    localparam int         TIMER_W   = 24;

    // One step of the Galois LFSR; a nonzero state never maps to zero.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/bingame_debounce.sv
// Button conditioning: 2-flop synchroniser, stability counter, accepted level
// and a one-cycle pulse on each accepted press.
// The synchroniser resets to 1 so a button held through reset release looks
// pressed; the pulse is only armed after a released level has been observed.
module bingame_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw,
    output logic pulse
);

    localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

    logic        sync1;
    logic        sync2;
    logic        level;
    logic        armed;
    logic        pulse_q;
    logic [15:0] cnt;
    logic        flip;

    assign flip  = (sync2 != level) && (cnt == CNT_LAST);
    assign pulse = pulse_q & ena;

    // Synchronise, count stable disagreeing samples, flip level, emit pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b0;
            armed   <= 1'b0;
            pulse_q <= 1'b0;
            cnt     <= 16'd0;
        end else if (ena) begin
            sync1   <= raw;
            sync2   <= sync1;
            pulse_q <= flip && !level && armed;
            if (!sync2)
                armed <= 1'b1;
            if (sync2 == level) begin
                cnt <= 16'd0;
            end else if (flip) begin
                level <= ~level;
                cnt   <= 16'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/bingame_round_ctrl.sv
// Game-round controller: debounced start/submit, LFSR target generation,
// answer judging and saturating streak score.
// Optional round timeout compiled in with `define BINGAME_TIMEOUT_EN.
module bingame_round_ctrl
    import bingame_pkg::*;
#(
    parameter int         DEB_CYCLES   = 4,
    parameter int         ROUND_CYCLES = 1000,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] sw,
    input  logic       btn_start,
    input  logic       btn_submit,
    output logic [7:0] target,
    output logic [3:0] score,
    output logic       led_ok,
    output logic       led_fail,
    output logic       timeout,
    output logic       busy
);

    if (DEB_CYCLES < 1 || DEB_CYCLES > 65535 || ROUND_CYCLES < 2 ||
        ROUND_CYCLES > 24'hFFFFFF || LFSR_SEED == 8'd0) begin : g_bad_param
        $error("bingame_round_ctrl: parameter out of range");
    end

    logic        start_p;
    logic        submit_p;
    logic [7:0]  lfsr;
    state_t      state;
    state_t      state_nxt;
    logic [7:0]  target_nxt;
    logic [3:0]  score_nxt;
    logic        ok_nxt;
    logic        fail_nxt;
    logic        expired;

    bingame_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .raw   (btn_start),
        .pulse (start_p)
    );

    bingame_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_submit (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .raw   (btn_submit),
        .pulse (submit_p)
    );

    // Free-running target source, advances every enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else if (ena)
            lfsr <= lfsr_step(lfsr);
    end

`ifdef BINGAME_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ROUND_CYCLES - 1);

    logic [TIMER_W-1:0] timer;
    logic               timeout_q;

    assign expired = (state == WAIT) && (timer == TIMER_LAST);
    assign timeout = timeout_q;

    // Round timer: zero outside WAIT, so it starts from 0 on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timer <= '0;
        else if (ena)
            timer <= (state == WAIT) ? timer + 1'b1 : '0;
    end

    // Timeout flag: set on expiry without a submit, cleared by a new round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timeout_q <= 1'b0;
        else if (ena) begin
            if (state != WAIT && start_p)
                timeout_q <= 1'b0;
            else if (expired && !submit_p)
                timeout_q <= 1'b1;
        end
    end
`else
    assign expired = 1'b0;
    assign timeout = 1'b0;
`endif

    assign busy = (state == WAIT);

    // FSM and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            target   <= 8'd0;
            score    <= 4'd0;
            led_ok   <= 1'b0;
            led_fail <= 1'b0;
        end else begin
            state    <= state_nxt;
            target   <= target_nxt;
            score    <= score_nxt;
            led_ok   <= ok_nxt;
            led_fail <= fail_nxt;
        end
    end

    // Next-state: start opens a round, submit (or expiry) judges it.
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        score_nxt  = score;
        ok_nxt     = led_ok;
        fail_nxt   = led_fail;
        if (ena) begin
            case (state)
                IDLE, RESULT: begin
                    if (start_p) begin
                        state_nxt  = WAIT;
                        target_nxt = lfsr;
                        ok_nxt     = 1'b0;
                        fail_nxt   = 1'b0;
                    end
                end
                WAIT: begin
                    if (submit_p) begin
                        state_nxt = RESULT;
                        if (sw == target) begin
                            score_nxt = (score == SCORE_MAX) ? score : score + 4'd1;
                            ok_nxt    = 1'b1;
                        end else begin
                            score_nxt = 4'd0;
                            fail_nxt  = 1'b1;
                        end
                    end else if (expired) begin
                        state_nxt = RESULT;
                        score_nxt = 4'd0;
                        fail_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bingame_round_ctrl.sv
// Self-checking bench for bingame_round_ctrl against a behavioural game model.
module tb_bingame_round_ctrl;

    localparam int         DEB  = 4;
    localparam int         RC   = 20;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] sw;
    logic       btn_start;
    logic       btn_submit;
    logic [7:0] target;
    logic [3:0] score;
    logic       led_ok;
    logic       led_fail;
    logic       timeout;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int ecount = 0;

    int         m_score;
    logic [7:0] m_target;
    logic       m_ok, m_fail, m_to, m_busy;

    bingame_round_ctrl #(
        .DEB_CYCLES   (DEB),
        .ROUND_CYCLES (RC),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .sw         (sw),
        .btn_start  (btn_start),
        .btn_submit (btn_submit),
        .target     (target),
        .score      (score),
        .led_ok     (led_ok),
        .led_fail   (led_fail),
        .timeout    (timeout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Target sequence: seed divided by x repeatedly modulo x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_at(input int k);
        logic [7:0] s;
        s = SEED;
        for (int i = 0; i < k; i++)
            s = (s % 2 == 1) ? ((s / 2) ^ 8'hB8) : (s / 2);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (ena) ecount++;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".target"},   32'(target),   32'(m_target));
        check({tag, ".score"},    32'(score),    32'(m_score));
        check({tag, ".led_ok"},   32'(led_ok),   32'(m_ok));
        check({tag, ".led_fail"}, 32'(led_fail), 32'(m_fail));
        check({tag, ".timeout"},  32'(timeout),  32'(m_to));
        check({tag, ".busy"},     32'(busy),     32'(m_busy));
    endtask

    task automatic model_reset();
        m_score = 0; m_target = 8'd0;
        m_ok = 0; m_fail = 0; m_to = 0; m_busy = 0;
    endtask

    task automatic model_judge(input logic [7:0] ans);
        if (ans == m_target) begin
            m_score = (m_score < 15) ? m_score + 1 : 15;
            m_ok = 1;
        end else begin
            m_score = 0;
            m_fail = 1;
        end
        m_busy = 0;
        m_to = 0;
    endtask

    // Press start for 10 cycles; round opens on the 7th edge after the press.
    task automatic start_round(input string tag);
        int e0;
        e0 = ecount;
        btn_start = 1'b1;
        repeat (6) tick();
        check({tag, ".pre_busy"}, 32'(busy), 32'd0);
        tick();
        m_target = lfsr_at(e0 + 6);
        m_busy = 1; m_ok = 0; m_fail = 0; m_to = 0;
        check_all(tag);
        check({tag, ".nonzero"}, 32'(target != 8'd0), 32'd1);
        repeat (3) tick();
        btn_start = 1'b0;
    endtask

    task automatic submit_answer(input string tag, input logic [7:0] ans, input int hold);
        sw = ans;
        btn_submit = 1'b1;
        repeat (hold) tick();
        btn_submit = 1'b0;
        repeat (10) tick();
        model_judge(ans);
        check_all(tag);
    endtask

    initial begin
        logic [7:0] ans;
        int e0;
        rst_n = 1'b0; ena = 1'b1; sw = 8'd0; btn_start = 1'b0; btn_submit = 1'b0;
        model_reset();
        repeat (3) tick();
        check_all("reset");
        rst_n = 1'b1;
        ecount = 0;
        repeat (4) tick();

        start_round("first");
        submit_answer("first_ok", m_target, 6);

        for (int r = 0; r < 17; r++) begin
            start_round("sat_start");
            submit_answer("sat_ok", m_target, $urandom_range(4, 9));
        end

        start_round("wrong_start");
        submit_answer("wrong", m_target ^ 8'($urandom_range(1, 255)), 5);

        for (int r = 0; r < 3; r++) begin
            start_round("to3_start");
            submit_answer("to3_ok", m_target, $urandom_range(4, 9));
        end
        start_round("lsb_start");
        submit_answer("lsb_wrong", m_target ^ 8'h01, 6);
        repeat (20) tick();
        check_all("target_held");

        for (int r = 0; r < 10; r++) begin
            start_round("rnd_start");
            ans = ($urandom_range(0, 1) == 1) ? m_target : m_target ^ 8'($urandom_range(1, 255));
            submit_answer("rnd_judge", ans, $urandom_range(4, 9));
        end

        start_round("glitch_start");
        sw = m_target;
        btn_submit = 1'b1;
        repeat (3) tick();
        btn_submit = 1'b0;
        repeat (5) tick();
        check_all("glitch");

        btn_start = 1'b1; btn_submit = 1'b1;
        repeat (8) tick();
        btn_start = 1'b0; btn_submit = 1'b0;
        repeat (10) tick();
        model_judge(m_target);
        check_all("simul");

        start_round("ena_start");
        ena = 1'b0;
        sw = m_target;
        btn_submit = 1'b1;
        repeat (20) tick();
        btn_submit = 1'b0;
        repeat (30) tick();
        check_all("ena_hold");
        ena = 1'b1;
        repeat (2) tick();
        submit_answer("ena_judge", m_target, 6);
        start_round("ena_resume");
        submit_answer("ena_resume_ok", m_target, 6);

`ifdef BINGAME_TIMEOUT_EN
        e0 = ecount;
        btn_start = 1'b1;
        repeat (7) tick();
        btn_start = 1'b0;
        m_target = lfsr_at(e0 + 6);
        m_busy = 1; m_ok = 0; m_fail = 0; m_to = 0;
        repeat (19) tick();
        check_all("to_pre");
        tick();
        m_busy = 0; m_fail = 1; m_to = 1; m_score = 0;
        check_all("to_expire");
        repeat (10) tick();

        e0 = ecount;
        btn_start = 1'b1;
        repeat (7) tick();
        btn_start = 1'b0;
        m_target = lfsr_at(e0 + 6);
        m_busy = 1; m_ok = 0; m_fail = 0; m_to = 0;
        check_all("to19_start");
        repeat (13) tick();
        sw = m_target;
        btn_submit = 1'b1;
        repeat (7) tick();
        btn_submit = 1'b0;
        model_judge(m_target);
        check_all("to19_judge");
        repeat (10) tick();
`else
        start_round("long_start");
        repeat (200) tick();
        check_all("no_timeout");
        submit_answer("long_ok", m_target, 6);
`endif

        start_round("rst_start");
        btn_start = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        repeat (2) tick();
        rst_n = 1'b1;
        ecount = 0;
        repeat (20) tick();
        check_all("rst_held_btn");
        btn_start = 1'b0;
        repeat (10) tick();
        start_round("rst_restart");
        submit_answer("rst_ok", m_target, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
